// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-unit state encoding and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that can reach 'width' (ceil(log2(width+1))).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit combinational full adder.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start, a, b, cin in;
//        busy, done (1-cycle pulse), sum, cout out (all registered).
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sreg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_c;
  logic             c_c;
  logic             last_c;
  logic [WIDTH-1:0] sum_word_c;

  fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (s_c),
    .cout (c_c)
  );

  // Sum register with the current bit shifted in at the MSB; also the final word on the last bit.
  assign sum_word_c = WIDTH'({s_c, sreg} >> 1);
  assign last_c     = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift/counter datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            sreg  <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sreg  <= sum_word_c;
          carry <= c_c;
          cnt   <= cnt + CW'(1);
          if (last_c) begin
            sum  <= sum_word_c;
            cout <= c_c;
            done <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    int         e;
  } req_t;

  req_t q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      input logic [7:0] es, input logic ec);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    tick();
    start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("done_early", 32'(done), 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("done_early", 32'(done), 32'd0);
      chk("busy_run", 32'(busy), 32'd1);
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    tick();
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(es));
    chk("cout_hold", 32'(cout), 32'(ec));
  endtask

  task automatic run1(input logic ta, input logic tb_, input logic tc,
                      input logic es, input logic ec);
    start1 = 1'b1; a1 = ta; b1 = tb_; cin1 = tc;
    tick();
    start1 = 1'b0; a1 = ~ta; b1 = ~tb_; cin1 = ~tc;
    chk("w1_done_early", 32'(done1), 32'd0);
    chk("w1_busy", 32'(busy1), 32'd1);
    tick();
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'(es));
    chk("w1_cout", 32'(cout1), 32'(ec));
    tick();
    chk("w1_done_fall", 32'(done1), 32'd0);
    chk("w1_busy_fall", 32'(busy1), 32'd0);
  endtask

  initial begin
    int dcount;
    int cyc;
    int next_acc;
    int prev_done;
    logic exp_done;
    req_t r;

    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);

    // Basic additions and overflow into cout
    run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start pulses while running are ignored
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3 || k == 5) begin
        start = 1'b1; a = 8'hAA; b = 8'hBB; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("ign_busy", 32'(busy), (k <= 8) ? 32'd1 : 32'd0);
      if (done) begin
        dcount++;
        chk("ign_sum", 32'(sum), 32'h46);
        chk("ign_cout", 32'(cout), 32'd0);
      end
    end
    start = 1'b0;
    chk("ign_done_count", 32'(dcount), 32'd1);

    // Reset in the middle of an operation aborts it
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    run8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);

    // Single-bit instance: exactly one RUN cycle
    run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Sweep with start held high: results and done spacing
    dcount = 0; cyc = 0; next_acc = 1; prev_done = -1;
    start = 1'b1;
    for (int i = 0; i < 11000 && dcount < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      r.a = a; r.b = b; r.c = cin;
      tick();
      cyc++;
      if (cyc == next_acc) begin
        r.e = cyc;
        q.push_back(r);
        next_acc += 10;
      end
      exp_done = (q.size() > 0) && (cyc == q[0].e + 8);
      chk("sweep_done", 32'(done), 32'(exp_done));
      if (done && q.size() > 0) begin
        r = q.pop_front();
        dcount++;
        chk("sweep_result", 32'({cout, sum}), 32'(9'(r.a) + 9'(r.b) + 9'(r.c)));
        if (prev_done >= 0) chk("sweep_spacing", 32'(cyc - prev_done), 32'd10);
        prev_done = cyc;
      end
    end
    start = 1'b0;
    chk("sweep_count", 32'(dcount), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
